// File: rtl/spram_burst_reader.sv
// spram_burst_reader: streams a (base, length) burst out of a registered-read SPRAM as valid/ready beats
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start, base_addr, length burst command (sampled only while idle; length 0..2^ADDR_WIDTH)
//   busy, done              not-idle flag, one-cycle end-of-burst pulse
//   ram_cs/we/oe/addr       SPRAM control and address (we tied low)
//   ram_rdata               SPRAM read data, valid the cycle after its address
//   m_data/valid/ready/last output stream
module spram_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    localparam logic [ADDR_WIDTH:0] REM_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    state_t state, state_next;
    logic done_next;
    logic [ADDR_WIDTH:0] remaining;
    logic pending, pending_last;
    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic [1:0] fifo_last;
    logic wr_ptr, rd_ptr;
    logic [1:0] count;
    logic pop, issue, fifo_empty_next;
    logic [2:0] occupancy;
    assign pop = m_valid & m_ready;
    // Words held or in flight after this edge; a read is issued only if it will find a free slot.
    assign occupancy = {1'b0, count} + {2'b0, pending} - {2'b0, pop};
    assign issue = (state == RUN) && (remaining != '0) && (occupancy < 3'd2);
    // Only consulted when nothing is in flight, so no push can land this edge.
    assign fifo_empty_next = (count == {1'b0, pop});
    assign m_valid = (count != 2'd0);
    assign m_data = fifo_data[rd_ptr];
    assign m_last = m_valid & fifo_last[rd_ptr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            done <= 1'b0;
        end else begin
            state <= state_next;
            done <= done_next;
        end
    end
    // The last accept and the return to IDLE share an edge, so done follows the final beat directly.
    always_comb begin
        state_next = state;
        done_next = 1'b0;
        case (state)
            IDLE: begin
                state_next = (start && length != '0) ? RUN : IDLE;
                done_next = start && length == '0;
            end
            RUN: if (remaining == '0 && !pending) begin
                state_next = fifo_empty_next ? IDLE : DRAIN;
                done_next = fifo_empty_next;
            end
            DRAIN: begin
                state_next = fifo_empty_next ? IDLE : DRAIN;
                done_next = fifo_empty_next;
            end
            default: state_next = IDLE;
        endcase
    end
    // RAM stays selected through the capture-only and drain cycles so data_out is not gated off.
    always_comb begin
        busy = (state != IDLE);
        ram_cs = busy;
        ram_oe = busy;
        ram_we = 1'b0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr <= '0;
            remaining <= '0;
            pending <= 1'b0;
            pending_last <= 1'b0;
        end else begin
            pending <= issue;
            pending_last <= issue && remaining == REM_ONE;
            if (state == IDLE && start && length != '0) begin
                ram_addr <= base_addr;
                remaining <= length;
            end else if (issue) begin
                ram_addr <= ram_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                remaining <= remaining - REM_ONE;
            end
        end
    end
    // Two-entry skid FIFO; a word read last cycle is captured unconditionally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_last <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count <= 2'd0;
        end else begin
            if (pending) begin
                fifo_data[wr_ptr] <= ram_rdata;
                fifo_last[wr_ptr] <= pending_last;
                wr_ptr <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, pending} - {1'b0, pop};
        end
    end
endmodule
